// File: rtl/seq_alu_if.sv
// Start/done handshake bundle for seq_alu: request fields from the master, result and flags back.
interface seq_alu_if #(parameter int N = 8);
   logic         start;
   logic [3:0]   op;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic [N-1:0] result_hi;
   logic         carry;
   logic         negative;
   logic         overflow;
   logic         div_zero;
   logic         zero;
   logic         illegal;

   modport master (
      output start, op, a, b,
      input  busy, done, result, result_hi, carry, negative, overflow, div_zero, zero, illegal
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, result_hi, carry, negative, overflow, div_zero, zero, illegal
   );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle N-bit ALU: single-cycle logic/arith/shift, iterative shift-add MUL and restoring DIV/MOD.
// Define SEQ_ALU_ASR_EN to turn opcode 11 into arithmetic shift right instead of a reserved opcode.
//
// state  | meaning
// S_IDLE | waiting for start; result and flags hold
// S_EXEC | iterating; cnt==0 marks the completing cycle
module seq_alu #(
   parameter  int N   = 8,
   localparam int SHW = $clog2(N),
   localparam int CW  = $clog2(N) + 1
) (
   input  logic     clk,
   input  logic     rst,
   seq_alu_if.slave bus
);
   localparam logic [3:0] OP_AND = 4'd0, OP_OR  = 4'd1, OP_XOR = 4'd2, OP_NOT = 4'd3;
   localparam logic [3:0] OP_ADD = 4'd4, OP_SUB = 4'd5, OP_MUL = 4'd6, OP_DIV = 4'd7;
   localparam logic [3:0] OP_MOD = 4'd8, OP_SHL = 4'd9, OP_SHR = 4'd10, OP_ASR = 4'd11;

   typedef enum logic {S_IDLE, S_EXEC} state_t;

   state_t         state, state_nxt;
   logic [3:0]     op_r;
   logic [N-1:0]   a_r, b_r;
   logic [N-1:0]   p_hi, p_lo;
   logic [CW-1:0]  cnt;
   logic           accept, last, iterative;
   logic [N:0]     add_sum, div_sh, div_diff, sum_ab, diff_ab;
   logic [N-1:0]   step_hi, step_lo, r_lo, r_hi;
   logic           f_carry, f_neg, f_ovf, f_dz, f_ill;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start) state_nxt = S_EXEC;
         S_EXEC:  if (last)      state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy  = (state == S_EXEC);
      accept    = (state == S_IDLE) && bus.start;
      last      = (state == S_EXEC) && (cnt == '0);
      iterative = (bus.op == OP_MUL) ||
                  (((bus.op == OP_DIV) || (bus.op == OP_MOD)) && (bus.b != '0));
   end

   // One iteration step. MUL: {p_hi,p_lo} is the shifting product with the multiplier in p_lo.
   // DIV/MOD: p_hi is the partial remainder, p_lo shifts the dividend out and the quotient in.
   always_comb begin
      add_sum  = {1'b0, p_hi} + {1'b0, (p_lo[0] ? a_r : {N{1'b0}})};
      div_sh   = {p_hi, p_lo[N-1]};
      div_diff = div_sh - {1'b0, b_r};
      if (op_r == OP_MUL) begin
         step_hi = add_sum[N:1];
         step_lo = {add_sum[0], p_lo[N-1:1]};
      end else begin
         step_hi = div_diff[N] ? div_sh[N-1:0] : div_diff[N-1:0];
         step_lo = {p_lo[N-2:0], ~div_diff[N]};
      end
   end

   always_comb begin
      sum_ab  = {1'b0, a_r} + {1'b0, b_r};
      diff_ab = {1'b0, a_r} - {1'b0, b_r};
      r_lo    = '0;
      r_hi    = '0;
      f_carry = 1'b0;
      f_neg   = 1'b0;
      f_ovf   = 1'b0;
      f_dz    = 1'b0;
      f_ill   = 1'b0;
      case (op_r)
         OP_AND: r_lo = a_r & b_r;
         OP_OR:  r_lo = a_r | b_r;
         OP_XOR: r_lo = a_r ^ b_r;
         OP_NOT: r_lo = ~a_r;
         OP_ADD: begin r_lo = sum_ab[N-1:0];  f_carry = sum_ab[N];  end
         OP_SUB: begin r_lo = diff_ab[N-1:0]; f_neg   = diff_ab[N]; end
         OP_MUL: begin r_lo = step_lo; r_hi = step_hi; f_ovf = |step_hi; end
         OP_DIV: if (b_r == '0) f_dz = 1'b1; else r_lo = step_lo;
         OP_MOD: if (b_r == '0) f_dz = 1'b1; else r_lo = step_hi;
         OP_SHL: r_lo = a_r << b_r[SHW-1:0];
         OP_SHR: r_lo = a_r >> b_r[SHW-1:0];
`ifdef SEQ_ALU_ASR_EN
         OP_ASR: r_lo = N'($signed(a_r) >>> b_r[SHW-1:0]);
`endif
         default: f_ill = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_r          <= '0;
         a_r           <= '0;
         b_r           <= '0;
         p_hi          <= '0;
         p_lo          <= '0;
         cnt           <= '0;
         bus.done      <= 1'b0;
         bus.result    <= '0;
         bus.result_hi <= '0;
         bus.carry     <= 1'b0;
         bus.negative  <= 1'b0;
         bus.overflow  <= 1'b0;
         bus.div_zero  <= 1'b0;
         bus.zero      <= 1'b0;
         bus.illegal   <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (accept) begin
            op_r <= bus.op;
            a_r  <= bus.a;
            b_r  <= bus.b;
            p_hi <= '0;
            p_lo <= (bus.op == OP_MUL) ? bus.b : bus.a;
            cnt  <= iterative ? CW'(N - 1) : '0;
         end else if (state == S_EXEC) begin
            p_hi <= step_hi;
            p_lo <= step_lo;
            if (cnt == '0) begin
               bus.done      <= 1'b1;
               bus.result    <= r_lo;
               bus.result_hi <= r_hi;
               bus.carry     <= f_carry;
               bus.negative  <= f_neg;
               bus.overflow  <= f_ovf;
               bus.div_zero  <= f_dz;
               bus.zero      <= (r_lo == '0);
               bus.illegal   <= f_ill;
            end else begin
               cnt <= cnt - 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at N=8; honours SEQ_ALU_ASR_EN for opcode 11.
module tb_seq_alu;
   localparam int N = 8;
   // flag vector order: {carry, negative, overflow, div_zero, zero, illegal}
   localparam logic [5:0] F_C = 6'b100000, F_N = 6'b010000, F_O = 6'b001000;
   localparam logic [5:0] F_D = 6'b000100, F_Z = 6'b000010, F_I = 6'b000001;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   lat;

   always #5 clk = ~clk;

   seq_alu_if #(.N(N)) bus ();
   seq_alu #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

   function automatic logic [5:0] flags();
      return {bus.carry, bus.negative, bus.overflow, bus.div_zero, bus.zero, bus.illegal};
   endfunction

   // Issue one op, scramble inputs after t0, return edges from t0 to done in lat (64 = timeout).
   task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(negedge clk);
      bus.start = 1'b0; bus.op = 4'hF; bus.a = 8'hA5; bus.b = 8'h5A;
      lat = 0;
      while (!bus.done && lat < 64) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.busy, bus.done, bus.result, bus.result_hi, flags()} !== '0) begin
         errors++;
         $display("FAIL reset_state: got busy=%b done=%b res=%h hi=%h flags=%b, want all 0",
                  bus.busy, bus.done, bus.result, bus.result_hi, flags());
      end
      rst = 1'b0;
   endtask

   task automatic test_logic();
      logic [3:0] ops [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
      logic [7:0] exp [4] = '{8'h30, 8'hFC, 8'hCC, 8'h0F};
      for (int i = 0; i < 4; i++) begin
         run_op(ops[i], 8'hF0, 8'h3C);
         checks++;
         if (lat != 1 || bus.result !== exp[i] || bus.result_hi !== 8'h00 || flags() !== 6'b0) begin
            errors++;
            $display("FAIL logic_op%0d: got lat=%0d res=%h hi=%h flags=%b, want lat=1 res=%h hi=00 flags=000000",
                     ops[i], lat, bus.result, bus.result_hi, flags(), exp[i]);
         end
      end
   endtask

   task automatic test_add_sub();
      run_op(4'd4, 8'd200, 8'd100);
      checks++;
      if (lat != 1 || bus.result !== 8'd44 || flags() !== F_C) begin
         errors++;
         $display("FAIL add_carry: got lat=%0d res=%0d flags=%b, want lat=1 res=44 flags=%b",
                  lat, bus.result, flags(), F_C);
      end
      run_op(4'd5, 8'd5, 8'd9);
      checks++;
      if (lat != 1 || bus.result !== 8'd252 || flags() !== F_N) begin
         errors++;
         $display("FAIL sub_borrow: got lat=%0d res=%0d flags=%b, want lat=1 res=252 flags=%b",
                  lat, bus.result, flags(), F_N);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse: got done=%b one cycle later, want 0", bus.done);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (bus.result !== 8'd252 || flags() !== F_N) begin
         errors++;
         $display("FAIL hold: got res=%0d flags=%b, want res=252 flags=%b", bus.result, flags(), F_N);
      end
      run_op(4'd5, 8'd9, 8'd9);
      checks++;
      if (bus.result !== 8'd0 || flags() !== F_Z) begin
         errors++;
         $display("FAIL sub_zero: got res=%0d flags=%b, want res=0 flags=%b", bus.result, flags(), F_Z);
      end
   endtask

   task automatic test_mul();
      run_op(4'd6, 8'd15, 8'd17);
      checks++;
      if (lat != 8 || bus.result !== 8'd255 || bus.result_hi !== 8'd0 || flags() !== 6'b0) begin
         errors++;
         $display("FAIL mul_15x17: got lat=%0d res=%0d hi=%0d flags=%b, want lat=8 res=255 hi=0 flags=000000",
                  lat, bus.result, bus.result_hi, flags());
      end
      run_op(4'd6, 8'd16, 8'd16);
      checks++;
      if (lat != 8 || bus.result !== 8'd0 || bus.result_hi !== 8'd1 || flags() !== (F_O | F_Z)) begin
         errors++;
         $display("FAIL mul_16x16: got lat=%0d res=%0d hi=%0d flags=%b, want lat=8 res=0 hi=1 flags=%b",
                  lat, bus.result, bus.result_hi, flags(), F_O | F_Z);
      end
      run_op(4'd6, 8'd255, 8'd255);
      checks++;
      if (bus.result !== 8'd1 || bus.result_hi !== 8'd254 || flags() !== F_O) begin
         errors++;
         $display("FAIL mul_255x255: got res=%0d hi=%0d flags=%b, want res=1 hi=254 flags=%b",
                  bus.result, bus.result_hi, flags(), F_O);
      end
   endtask

   task automatic test_div();
      run_op(4'd7, 8'd100, 8'd7);
      checks++;
      if (lat != 8 || bus.result !== 8'd14 || bus.result_hi !== 8'd0 || flags() !== 6'b0) begin
         errors++;
         $display("FAIL div_100_7: got lat=%0d res=%0d hi=%0d flags=%b, want lat=8 res=14 hi=0 flags=000000",
                  lat, bus.result, bus.result_hi, flags());
      end
      run_op(4'd8, 8'd100, 8'd7);
      checks++;
      if (lat != 8 || bus.result !== 8'd2 || flags() !== 6'b0) begin
         errors++;
         $display("FAIL mod_100_7: got lat=%0d res=%0d flags=%b, want lat=8 res=2 flags=000000",
                  lat, bus.result, flags());
      end
      run_op(4'd7, 8'd250, 8'd3);
      checks++;
      if (bus.result !== 8'd83) begin
         errors++;
         $display("FAIL div_250_3: got res=%0d, want 83", bus.result);
      end
      run_op(4'd7, 8'd9, 8'd0);
      checks++;
      if (lat != 1 || bus.result !== 8'd0 || flags() !== (F_D | F_Z)) begin
         errors++;
         $display("FAIL div_by_zero: got lat=%0d res=%0d flags=%b, want lat=1 res=0 flags=%b",
                  lat, bus.result, flags(), F_D | F_Z);
      end
      run_op(4'd8, 8'd9, 8'd0);
      checks++;
      if (lat != 1 || bus.result !== 8'd0 || flags() !== (F_D | F_Z)) begin
         errors++;
         $display("FAIL mod_by_zero: got lat=%0d res=%0d flags=%b, want lat=1 res=0 flags=%b",
                  lat, bus.result, flags(), F_D | F_Z);
      end
   endtask

   task automatic test_shift();
      logic [7:0] exp_asr;
      logic [5:0] exp_f;
      run_op(4'd9, 8'h03, 8'h02);
      checks++;
      if (lat != 1 || bus.result !== 8'h0C) begin
         errors++;
         $display("FAIL shl: got lat=%0d res=%h, want lat=1 res=0c", lat, bus.result);
      end
      run_op(4'd10, 8'h80, 8'h03);
      checks++;
      if (lat != 1 || bus.result !== 8'h10 || flags() !== 6'b0) begin
         errors++;
         $display("FAIL shr: got lat=%0d res=%h flags=%b, want lat=1 res=10 flags=000000",
                  lat, bus.result, flags());
      end
`ifdef SEQ_ALU_ASR_EN
      exp_asr = 8'hF0; exp_f = 6'b0;
`else
      exp_asr = 8'h00; exp_f = F_Z | F_I;
`endif
      run_op(4'd11, 8'h80, 8'h03);
      checks++;
      if (lat != 1 || bus.result !== exp_asr || flags() !== exp_f) begin
         errors++;
         $display("FAIL op11: got lat=%0d res=%h flags=%b, want lat=1 res=%h flags=%b",
                  lat, bus.result, flags(), exp_asr, exp_f);
      end
      run_op(4'd15, 8'hFF, 8'hFF);
      checks++;
      if (lat != 1 || bus.result !== 8'h00 || bus.result_hi !== 8'h00 || flags() !== (F_Z | F_I)) begin
         errors++;
         $display("FAIL reserved_op15: got lat=%0d res=%h hi=%h flags=%b, want lat=1 res=00 hi=00 flags=%b",
                  lat, bus.result, bus.result_hi, flags(), F_Z | F_I);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      bus.start = 1'b1; bus.op = 4'd6; bus.a = 8'd15; bus.b = 8'd17;
      @(negedge clk);
      bus.start = 1'b0; bus.a = 8'hFF; bus.b = 8'hFF;
      lat = 0;
      while (!bus.done && lat < 64) begin
         @(negedge clk);
         lat++;
         if (lat == 2) begin
            bus.start = 1'b1; bus.op = 4'd4; bus.a = 8'd1; bus.b = 8'd1;
         end else if (lat == 3) begin
            bus.start = 1'b0;
         end
      end
      checks++;
      if (lat != 8 || bus.result !== 8'd255 || bus.result_hi !== 8'd0 || flags() !== 6'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL start_while_busy: got lat=%0d res=%0d hi=%0d flags=%b busy=%b, want lat=8 res=255 hi=0 flags=000000 busy=0",
                  lat, bus.result, bus.result_hi, flags(), bus.busy);
      end
      bus.start = 1'b1; bus.op = 4'd4; bus.a = 8'd3; bus.b = 8'd4;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept: got done=%b busy=%b, want done=0 busy=1", bus.done, bus.busy);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b1 || bus.result !== 8'd7 || flags() !== 6'b0) begin
         errors++;
         $display("FAIL b2b_result: got done=%b res=%0d flags=%b, want done=1 res=7 flags=000000",
                  bus.done, bus.result, flags());
      end
   endtask

   task automatic test_reset_mid_op();
      logic seen_done;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 4'd7; bus.a = 8'd100; bus.b = 8'd7;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.result, bus.result_hi, flags()} !== '0) begin
         errors++;
         $display("FAIL reset_mid_op: got busy=%b done=%b res=%h hi=%h flags=%b, want all 0",
                  bus.busy, bus.done, bus.result, bus.result_hi, flags());
      end
      seen_done = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen_done |= bus.done;
      end
      rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen_done |= bus.done;
      end
      checks++;
      if (seen_done !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_done: got done seen=%b, want 0", seen_done);
      end
      run_op(4'd4, 8'd1, 8'd1);
      checks++;
      if (lat != 1 || bus.result !== 8'd2 || flags() !== 6'b0) begin
         errors++;
         $display("FAIL add_after_reset: got lat=%0d res=%0d flags=%b, want lat=1 res=2 flags=000000",
                  lat, bus.result, flags());
      end
   endtask

   initial begin
      test_reset();
      test_logic();
      test_add_sub();
      test_mul();
      test_div();
      test_shift();
      test_back_to_back();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle N-bit ALU with a start/done handshake.
- Bundles logic, add/sub, shift, multiply, divide and modulo behind one registered interface for the lab datapath.
- Multiply is iterative shift-add; divide and modulo are iterative restoring division, one bit per cycle.
- Adds registered results, status flags, divide-by-zero detection and a busy/done protocol.

Parameters:
- N, 8: operand and result width; must be ≥2 and a power of two.
- SHW, $clog2(N): width of shift amount taken from b[SHW-1:0]. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only when busy=0.
- op  input  4  opcode, latched with start.
- a  input  N  operand A (unsigned), latched with start.
- b  input  N  operand B (unsigned), latched with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result and flags valid.
- result  output  N  low result word.
- result_hi  output  N  upper product word for MUL; 0 for all other ops.
- carry  output  1  ADD carry-out.
- negative  output  1  SUB borrow (b>a).
- overflow  output  1  MUL: result_hi≠0.
- div_zero  output  1  DIV/MOD with b=0.
- zero  output  1  result==0.
- illegal  output  1  reserved opcode.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: all outputs 0; FSM in IDLE.
- Reset mid-operation: abort immediately. No done pulse; partial results are discarded.
- FSM states:
  - IDLE: start=1 at edge t0 latches op/a/b, sets busy=1, goes to EXEC.
  - EXEC: iterates. The last iteration goes to IDLE and registers result, result_hi and flags.
  - Completion: done=1 and busy=0 for exactly one cycle.
- Opcodes:
  - 0 AND, 1 OR, 2 XOR, 3 NOT(a).
  - 4 ADD: {carry,result}=a+b.
  - 5 SUB: result=a-b mod 2^N; negative=(b>a).
  - 6 MUL: {result_hi,result}=a*b (2N bits); overflow=(result_hi≠0).
  - 7 DIV: quotient. 8 MOD: remainder.
  - 9 SHL: a<<b[SHW-1:0]. 10 SHR: logical a>>b[SHW-1:0].
  - 11-15 reserved.
- Latency, counted from the start edge t0:
  - Ops 0-5 and 9-10: done after edge t0+1.
  - Ops 6-8: done after edge t0+N.
  - DIV/MOD with b=0: done after edge t0+1; result=0, div_zero=1.
  - Reserved op: done after edge t0+1; result=0, illegal=1.
- Flags:
  - Flags not defined for the current op are 0.
  - zero is evaluated for every op, including error cases (result=0 gives zero=1).
- Output holding: result and flags hold until the next completion.
- Handshake:
  - start while busy=1 is ignored; the in-flight op and operands are unaffected.
  - start on the done cycle (busy=0) is accepted; back-to-back throughput has no bubble.
- Operand isolation: changes on a/b/op after t0 have no effect.
- Iterative datapath: N-cycle counter of width $clog2(N)+1; no combinational multiply or divide operators in EXEC.

Optional Feature:
- Macro: SEQ_ALU_ASR_EN.
- Defined: opcode 11 = ASR, arithmetic shift right of a by b[SHW-1:0] with sign fill from a[N-1]. Single-cycle latency, zero flag valid, illegal=0.
- Undefined: opcode 11 is reserved (result=0, illegal=1, latency 1).

Test Plan (N=8):
- ADD a=200, b=100 → done after t0+1; result=44, carry=1, zero=0. SUB a=5, b=9 → result=252, negative=1.
- MUL a=15, b=17 → done after t0+8; result=255, result_hi=0, overflow=0. MUL a=16, b=16 → result=0, result_hi=1, overflow=1, zero=1.
- DIV a=100, b=7 → result=14 after t0+8. MOD same operands → result=2. DIV a=9, b=0 → done after t0+1; result=0, div_zero=1.
- Start MUL; pulse start with op=4 at t0+3 → ignored, MUL result delivered. Start ADD on the done cycle → accepted; its done follows 1 cycle later.
- Start DIV; assert rst at t0+4 → all outputs 0 immediately, no done. After release, ADD 1+1 → result=2.
- SHR a=0x80, b=3 → 0x10. Op 11, a=0x80, b=3 → 0xF0 with SEQ_ALU_ASR_EN; result=0, illegal=1 without it.
